// File: rtl/box_round_judge_if.sv
// Player-facing bundle of the round judge: start/box-number/strike inputs and LED, score and pulse outputs.
interface box_round_judge_if;
    logic       start;
    logic [2:0] lfsr_address;
    logic [3:0] hit;
    logic [3:0] target_led;
    logic [7:0] score;
    logic [1:0] lives;
    logic       hit_ok;
    logic       miss;
    logic       game_over;
    logic       busy;

    modport master (
        output start, lfsr_address, hit,
        input  target_led, score, lives, hit_ok, miss, game_over, busy
    );

    modport slave (
        input  start, lfsr_address, hit,
        output target_led, score, lives, hit_ok, miss, game_over, busy
    );
endinterface

// File: rtl/box_round_judge.sv
// Round judge: lights a random box, judges strike/timeout, keeps score and lives.
// Judgement lands one cycle after the detecting edge; no backpressure, strikes outside SHOW are dropped.
module box_round_judge #(
    parameter int TIMEOUT_CYCLES = 50000000,
    parameter int GAP_CYCLES     = 12500000,
    parameter int LIVES          = 3
) (
    input logic              CLOCK_50,
    input logic              reset_n,
    box_round_judge_if.slave bus
);
    localparam int TMAX = (TIMEOUT_CYCLES > GAP_CYCLES) ? TIMEOUT_CYCLES : GAP_CYCLES;
    localparam int TW   = $clog2(TMAX);
    localparam logic [TW-1:0] SHOW_LAST  = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0] GAP_LAST   = TW'(GAP_CYCLES - 1);
    localparam logic [1:0]    LIVES_INIT = 2'(LIVES);

    typedef enum logic [2:0] {
        S_IDLE, S_ARM, S_SHOW, S_JUDGE_HIT, S_JUDGE_MISS, S_GAP, S_OVER
    } state_t;

    state_t        state, state_d;
    logic [TW-1:0] timer, timer_d;
    logic [3:0]    hit_prev;
    logic [3:0]    rise;
    logic [3:0]    target_q, target_d;
    logic [7:0]    score_q, score_d;
    logic [1:0]    lives_q, lives_d;
    logic          hit_ok_q, hit_ok_d;
    logic          miss_q, miss_d;
    logic          game_over_q, busy_q;

    assign rise = bus.hit & ~hit_prev;

    always_comb begin
        state_d  = state;
        timer_d  = '0;
        target_d = target_q;
        score_d  = score_q;
        lives_d  = lives_q;
        hit_ok_d = 1'b0;
        miss_d   = 1'b0;
        case (state)
            S_IDLE, S_OVER: begin
                if (bus.start) begin
                    score_d = '0;
                    lives_d = LIVES_INIT;
                    state_d = S_ARM;
                end
            end
            S_ARM: begin
                if (bus.lfsr_address >= 3'd1 && bus.lfsr_address <= 3'd4) begin
                    target_d = 4'b0001 << (bus.lfsr_address - 3'd1);
                    state_d  = S_SHOW;
                end
            end
            S_SHOW: begin
                timer_d = timer + 1'b1;
                // A correct strike outranks a timeout on the same edge.
                if (rise == target_q)
                    state_d = S_JUDGE_HIT;
                else if (rise != 4'b0000)
                    state_d = S_JUDGE_MISS;
                else if (timer == SHOW_LAST)
                    state_d = S_JUDGE_MISS;
            end
            S_JUDGE_HIT: begin
                score_d  = (score_q == 8'hFF) ? score_q : score_q + 8'd1;
                hit_ok_d = 1'b1;
                target_d = '0;
                state_d  = S_GAP;
            end
            S_JUDGE_MISS: begin
                lives_d  = lives_q - 2'd1;
                miss_d   = 1'b1;
                target_d = '0;
                state_d  = (lives_q == 2'd1) ? S_OVER : S_GAP;
            end
            S_GAP: begin
                timer_d = timer + 1'b1;
                if (timer == GAP_LAST)
                    state_d = S_ARM;
            end
            default: state_d = S_IDLE;
        endcase
        if (state_d != state)
            timer_d = '0;
    end

    always_ff @(posedge CLOCK_50) begin
        if (!reset_n) begin
            state       <= S_IDLE;
            timer       <= '0;
            hit_prev    <= '0;
            target_q    <= '0;
            score_q     <= '0;
            lives_q     <= LIVES_INIT;
            hit_ok_q    <= 1'b0;
            miss_q      <= 1'b0;
            game_over_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state       <= state_d;
            timer       <= timer_d;
            hit_prev    <= bus.hit;
            target_q    <= target_d;
            score_q     <= score_d;
            lives_q     <= lives_d;
            hit_ok_q    <= hit_ok_d;
            miss_q      <= miss_d;
            game_over_q <= (state_d == S_OVER);
            busy_q      <= !(state_d == S_IDLE || state_d == S_OVER);
        end
    end

    assign bus.target_led = target_q;
    assign bus.score      = score_q;
    assign bus.lives      = lives_q;
    assign bus.hit_ok     = hit_ok_q;
    assign bus.miss       = miss_q;
    assign bus.game_over  = game_over_q;
    assign bus.busy       = busy_q;
endmodule

// File: tb/tb_box_round_judge.sv
// Bench for box_round_judge: directed and random rounds scored against a round-level game model.
module tb_box_round_judge;
    localparam int T = 20;
    localparam int G = 4;
    localparam int L = 3;

    logic clk = 1'b0;
    logic reset_n;

    box_round_judge_if bus ();

    box_round_judge #(
        .TIMEOUT_CYCLES(T),
        .GAP_CYCLES    (G),
        .LIVES         (L)
    ) dut (
        .CLOCK_50(clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int n_tests   = 0;
    int n_fail    = 0;
    int exp_score = 0;
    int exp_lives = L;
    logic [2:0] inv_tab [4] = '{3'd0, 3'd7, 3'd5, 3'd6};

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        bus.start = 1'b0;
        bus.hit = 4'b0;
        bus.lfsr_address = 3'd0;
        step();
        step();
        reset_n = 1'b1;
        exp_score = 0;
        exp_lives = L;
        check("rst_led", bus.target_led, 0);
        check("rst_score", bus.score, 0);
        check("rst_lives", bus.lives, L);
        check("rst_pulse", {bus.hit_ok, bus.miss}, 0);
        check("rst_over", bus.game_over, 0);
        check("rst_busy", bus.busy, 0);
    endtask

    task automatic do_start();
        bus.hit = 4'b0;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        exp_score = 0;
        exp_lives = L;
        check("start_busy", bus.busy, 1);
        check("start_over", bus.game_over, 0);
        check("start_score", bus.score, 0);
        check("start_lives", bus.lives, L);
    endtask

    // mode 0: no strike (timeout); 1: strike vector at SHOW cycle d; 2: target held into SHOW, released, re-struck at d.
    task automatic play_round(input int pre, input int n_inv, input logic [2:0] addr,
                              input int mode, input logic [3:0] strike, input int d);
        logic [3:0] tgt;
        int         jc;
        bit         good;
        tgt  = 4'b0001 << (addr - 3'd1);
        good = (mode != 0) && (strike == tgt);
        jc   = (mode == 0) ? T - 1 : d;
        for (int i = 0; i < pre; i++) begin
            bus.lfsr_address = 3'($urandom_range(1, 4));
            bus.start = 1'($urandom_range(0, 1));
            bus.hit = 4'($urandom_range(0, 15));
            step();
            check("gap_led", bus.target_led, 0);
            check("gap_pulse", {bus.hit_ok, bus.miss}, 0);
            check("gap_busy", bus.busy, 1);
        end
        bus.hit = 4'b0;
        for (int i = 0; i < n_inv; i++) begin
            bus.lfsr_address = inv_tab[i % 4];
            bus.start = 1'($urandom_range(0, 1));
            step();
            check("arm_led", bus.target_led, 0);
            check("arm_pulse", {bus.hit_ok, bus.miss}, 0);
        end
        bus.lfsr_address = addr;
        bus.hit = (mode == 2) ? tgt : 4'b0;
        step();
        bus.lfsr_address = 3'($urandom_range(0, 7));
        check("show_led", bus.target_led, tgt);
        for (int k = 0; k <= jc; k++) begin
            if (mode == 1)
                bus.hit = (k == d) ? strike : 4'b0;
            else if (mode == 2)
                bus.hit = (k < 2 || k == d) ? tgt : 4'b0;
            bus.start = 1'($urandom_range(0, 1));
            step();
            if (k < jc) begin
                check("show_hold_led", bus.target_led, tgt);
                check("show_pulse", {bus.hit_ok, bus.miss}, 0);
            end else begin
                check("judge_led", bus.target_led, tgt);
                check("judge_pulse", {bus.hit_ok, bus.miss}, 0);
            end
        end
        bus.hit = 4'b0;
        bus.start = 1'b0;
        if (good)
            exp_score = (exp_score == 255) ? 255 : exp_score + 1;
        else
            exp_lives = exp_lives - 1;
        step();
        check("res_hit_ok", bus.hit_ok, good);
        check("res_miss", bus.miss, !good);
        check("res_led", bus.target_led, 0);
        check("res_score", bus.score, exp_score);
        check("res_lives", bus.lives, exp_lives);
        check("res_over", bus.game_over, exp_lives == 0);
        check("res_busy", bus.busy, exp_lives != 0);
    endtask

    task automatic over_and_restart();
        for (int i = 0; i < 3; i++) begin
            bus.lfsr_address = 3'($urandom_range(1, 4));
            bus.hit = 4'($urandom_range(0, 15));
            step();
            check("over_flag", bus.game_over, 1);
            check("over_busy", bus.busy, 0);
            check("over_lives", bus.lives, 0);
            check("over_score", bus.score, exp_score);
            check("over_pulse", {bus.hit_ok, bus.miss}, 0);
            check("over_led", bus.target_led, 0);
        end
        do_start();
    endtask

    initial begin
        int         pre;
        logic [2:0] addr;
        logic [3:0] tgt;
        logic [3:0] other;
        logic [3:0] strike;
        int         mode, sel, ob, d;

        reset_n = 1'b0;
        bus.start = 1'b0;
        bus.hit = 4'b0;
        bus.lfsr_address = 3'd0;
        @(negedge clk);
        do_reset();

        for (int i = 0; i < 3; i++) begin
            bus.lfsr_address = 3'($urandom_range(1, 4));
            bus.hit = 4'($urandom_range(0, 15));
            step();
            check("idle_led", bus.target_led, 0);
            check("idle_busy", bus.busy, 0);
        end
        do_start();

        play_round(0, 0, 3'd3, 1, 4'b0100, 5);
        play_round(G, 0, 3'd2, 1, 4'b1000, 3);
        play_round(G, 3, 3'd1, 1, 4'b0001, 0);
        play_round(G, 0, 3'd4, 0, 4'b0000, 0);
        play_round(G, 0, 3'd2, 1, 4'b0010, T - 1);
        play_round(G, 1, 3'd1, 2, 4'b0001, 7);
        play_round(G, 0, 3'd1, 1, 4'b0011, 4);
        over_and_restart();

        pre = 0;
        for (int r = 0; r < 60; r++) begin
            addr = 3'($urandom_range(1, 4));
            tgt = 4'b0001 << (addr - 3'd1);
            ob = $urandom_range(0, 2);
            if (ob >= int'(addr) - 1) ob++;
            other = 4'b0001 << ob;
            mode = $urandom_range(0, 2);
            sel = $urandom_range(0, 2);
            strike = (sel == 0) ? tgt : (sel == 1) ? other : (tgt | other);
            if (mode == 2) strike = tgt;
            d = (mode == 2) ? $urandom_range(3, T - 1) : $urandom_range(0, T - 1);
            play_round(pre, $urandom_range(0, 2), addr, mode, strike, d);
            if (exp_lives == 0) begin
                over_and_restart();
                pre = 0;
            end else begin
                pre = G;
            end
        end

        do_reset();
        do_start();
        for (int i = 0; i < 257; i++) begin
            addr = 3'($urandom_range(1, 4));
            tgt = 4'b0001 << (addr - 3'd1);
            play_round((i == 0) ? 0 : G, 0, addr, 1, tgt, $urandom_range(0, 2));
        end
        check("sat_score", bus.score, 255);

        do_reset();
        do_start();
        for (int i = 0; i < 5; i++)
            play_round((i == 0) ? 0 : G, 0, 3'd3, 1, 4'b0100, 1);
        play_round(G, 0, 3'd4, 1, 4'b0001, 2);
        bus.lfsr_address = 3'd2;
        for (int i = 0; i <= G; i++) step();
        check("mid_led", bus.target_led, 4'b0010);
        check("mid_score", bus.score, 5);
        check("mid_lives", bus.lives, 2);
        step();
        step();
        reset_n = 1'b0;
        step();
        check("mrst_led", bus.target_led, 0);
        check("mrst_score", bus.score, 0);
        check("mrst_lives", bus.lives, L);
        check("mrst_busy", bus.busy, 0);
        check("mrst_over", bus.game_over, 0);
        reset_n = 1'b1;
        exp_score = 0;
        exp_lives = L;
        for (int i = 0; i < 5; i++) begin
            bus.lfsr_address = 3'($urandom_range(1, 4));
            bus.hit = 4'($urandom_range(0, 15));
            step();
            check("mrst_idle_led", bus.target_led, 0);
            check("mrst_idle_busy", bus.busy, 0);
        end
        do_start();
        play_round(0, 0, 3'd4, 1, 4'b1000, 2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, tests run %0d", n_tests);
        $fatal(1);
    end
endmodule

// File: doc/box_round_judge.md
Name: box_round_judge

Overview:
- Consumer end of the random-box interface. Samples the 3-bit box number (1..4) from the LFSR box mapper at the start of each round, and lights that box's target LED.
- Detects player strikes on the four boxes and judges each round as hit, wrong box, or timeout.
- Keeps score and lives, and raises game-over. Sits between the LFSR/box mapper and the display/score logic in the game top level.

Parameters:
- TIMEOUT_CYCLES, 50000000: cycles a target stays lit before the round counts as a miss (minimum 2).
- GAP_CYCLES, 12500000: dark cycles between rounds (minimum 1).
- LIVES, 3: lives loaded at reset and at game start (range 1..3).

Ports:
- CLOCK_50  input  1  system clock; all logic on its rising edge.
- reset_n  input  1  synchronous, active-low reset.
- start  input  1  start request, level-sampled; used only in IDLE and OVER.
- lfsr_address  input  3  box number from the LFSR mapper; valid values are 1..4, free-running.
- hit  input  4  strike sensors, active high, level; bit i means box i+1 is struck.
- target_led  output  4  one-hot lit target; bit i lights box i+1.
- score  output  8  hits this game; saturates at 255.
- lives  output  2  remaining lives.
- hit_ok  output  1  one-cycle pulse for a correct strike.
- miss  output  1  one-cycle pulse for a wrong strike or timeout.
- game_over  output  1  high while in OVER.
- busy  output  1  high in every state except IDLE and OVER.

Behaviour:
- All outputs are registered.
- Reset (reset_n=0 at an edge):
  - State goes to IDLE.
  - target_led=0, score=0, lives=LIVES.
  - hit_ok=0, miss=0, game_over=0, busy=0.
  - Timer is cleared; hit_prev is set to 0.
- Reset wins over every other event, including mid-round.
- Strike edge detection:
  - hit_prev<=hit on every clock, in every state.
  - rise = hit & ~hit_prev.
  - rise is acted on only in SHOW. A key already held when SHOW is entered does not count.
- States: IDLE, ARM, SHOW, JUDGE_HIT, JUDGE_MISS, GAP, OVER.
- IDLE:
  - start=1: clear score, load lives=LIVES, go to ARM.
- ARM:
  - lfsr_address in 1..4: latch it as target, set target_led bit (target-1), clear timer, go to SHOW.
  - Otherwise (0, 5..7): stay in ARM and resample next cycle.
- SHOW: timer increments each cycle. Per clock edge, in priority order:
  - rise == exactly the target bit: go to JUDGE_HIT.
  - rise != 0 otherwise (wrong bit, or several bits including the target): go to JUDGE_MISS.
  - timer == TIMEOUT_CYCLES-1: go to JUDGE_MISS.
  - A correct rise on the same edge as the timeout counts as a hit.
- JUDGE_HIT (one cycle): score<=score+1, saturating at 255; hit_ok=1; target_led<=0; go to GAP.
- JUDGE_MISS (one cycle): lives<=lives-1; miss=1; target_led<=0. Next state is OVER if the old lives==1, else GAP.
- Round latency:
  - The detecting edge E moves SHOW to JUDGE.
  - The counter update, the pulse and LED-off are all visible after edge E+1.
  - Pulses last exactly one cycle.
- GAP:
  - Count GAP_CYCLES cycles with target_led=0, then go to ARM.
  - Strikes are ignored.
- OVER:
  - game_over=1; score and lives=0 are held.
  - start=1: clear score, lives=LIVES, game_over<=0, go to ARM.
- start outside IDLE and OVER is ignored.
- Timer width is sized for max(TIMEOUT_CYCLES, GAP_CYCLES). The timer is cleared on every state entry.

Test Plan:
All scenarios use TIMEOUT_CYCLES=20, GAP_CYCLES=4, LIVES=3.
1. Reset, start pulse, lfsr_address=3, rising strike on hit[2] 5 cycles into SHOW -> target_led=4'b0100 during SHOW; hit_ok one-cycle pulse; score=1; target_led=0; lives=3; next round after 4 gap cycles.
2. lfsr_address=2, strike on hit[3] -> miss pulse, lives=2, score unchanged. Repeat with lfsr_address=0 then 7 then 1 during ARM -> block stays in ARM on 0 and 7 and lights 4'b0001 only on 1.
3. No strike for 20 cycles of SHOW -> miss pulse on cycle 21, lives decrements. Correct strike on the 20th cycle -> hit_ok, no miss.
4. hit[0] held high before SHOW with target=1 -> no judgement. Release and re-press -> hit_ok. Simultaneous rise on hit[0] and hit[1] with target 1 -> miss.
5. Three misses -> lives=0, game_over=1, busy=0; start ignored mid-game. start in OVER -> score=0, lives=3, game_over=0. Force score to 255 then hit -> score stays 255.
6. reset_n=0 mid-SHOW with score=5 and lives=2 -> next cycle target_led=0, score=0, lives=3, IDLE; start is required to resume.
